// File: rtl/vga_timing_controller.sv
// VGA raster timing generator: programmable timing set, swapped in only at a frame boundary
// so a mode change never tears a frame.
module vga_timing_controller #(
  parameter int unsigned DEF_H_VISIBLE = 640,
  parameter int unsigned DEF_H_FP      = 16,
  parameter int unsigned DEF_H_SYNC    = 96,
  parameter int unsigned DEF_H_BP      = 48,
  parameter int unsigned DEF_V_VISIBLE = 480,
  parameter int unsigned DEF_V_FP      = 10,
  parameter int unsigned DEF_V_SYNC    = 2,
  parameter int unsigned DEF_V_BP      = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        en,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [10:0] cfg_h_visible,
  input  logic [10:0] cfg_h_fp,
  input  logic [10:0] cfg_h_sync,
  input  logic [10:0] cfg_h_bp,
  input  logic [10:0] cfg_v_visible,
  input  logic [10:0] cfg_v_fp,
  input  logic [10:0] cfg_v_sync,
  input  logic [10:0] cfg_v_bp,
  output logic        cfg_err,
  output logic [10:0] HCNT,
  output logic [10:0] VCNT,
  output logic        HS,
  output logic        VS,
  output logic        DE,
  output logic        line_start,
  output logic        frame_start,
  output logic        cfg_applied
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  // Set layout: [0..3] = h visible/fp/sync/bp, [4..7] = v visible/fp/sync/bp.
  localparam logic [7:0][10:0] DEF_SET = {
    11'(DEF_V_BP), 11'(DEF_V_SYNC), 11'(DEF_V_FP), 11'(DEF_V_VISIBLE),
    11'(DEF_H_BP), 11'(DEF_H_SYNC), 11'(DEF_H_FP), 11'(DEF_H_VISIBLE)
  };

  function automatic logic [12:0] f_total(input logic [10:0] a, input logic [10:0] b,
                                          input logic [10:0] c, input logic [10:0] d);
    return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  endfunction

  logic [1:0]        r_state, w_state_nxt;
  logic              r_first, w_first_nxt;
  logic [7:0][10:0]  r_act, w_act_nxt;
  logic [7:0][10:0]  r_pnd, w_pnd_nxt;
  logic [10:0]       r_hcnt, r_vcnt;
  logic              r_hs, r_vs, r_de, r_ls, r_fs;
  logic              r_applied, w_applied_nxt;
  logic              r_err, w_err_nxt;

  logic [7:0][10:0]  w_cfg, w_dec;
  logic              w_cfg_ok, w_accept;
  logic [12:0]       w_ht, w_vt;
  logic              w_h_last, w_v_last, w_frame_wrap, w_apply;
  logic [10:0]       w_nh, w_nv;
  logic [12:0]       w_hs_start, w_hs_end, w_vs_start, w_vs_end;
  logic              w_hs_n, w_vs_n, w_de_n;
  logic              w_adv, w_idle_out;

  assign w_cfg = {cfg_v_bp, cfg_v_sync, cfg_v_fp, cfg_v_visible,
                  cfg_h_bp, cfg_h_sync, cfg_h_fp, cfg_h_visible};

  assign cfg_ready = (r_state != ST_PEND);
  assign w_accept  = cfg_valid && cfg_ready;

  always_comb begin
    w_cfg_ok = (f_total(w_cfg[0], w_cfg[1], w_cfg[2], w_cfg[3]) <= 13'd2048) &&
               (f_total(w_cfg[4], w_cfg[5], w_cfg[6], w_cfg[7]) <= 13'd2048);
    for (int i = 0; i < 8; i++) begin
      if (w_cfg[i] == 11'd0) w_cfg_ok = 1'b0;
    end
  end

  assign w_ht     = f_total(r_act[0], r_act[1], r_act[2], r_act[3]);
  assign w_vt     = f_total(r_act[4], r_act[5], r_act[6], r_act[7]);
  assign w_h_last = ({2'b00, r_hcnt} == w_ht - 13'd1);
  assign w_v_last = ({2'b00, r_vcnt} == w_vt - 13'd1);

  always_comb begin
    w_nh         = r_hcnt + 11'd1;
    w_nv         = r_vcnt;
    w_frame_wrap = 1'b0;
    if (r_first) begin
      w_nh = '0;
      w_nv = '0;
    end else if (w_h_last) begin
      w_nh = '0;
      if (w_v_last) begin
        w_nv         = '0;
        w_frame_wrap = 1'b1;
      end else begin
        w_nv = r_vcnt + 11'd1;
      end
    end
  end

  // The pixel that starts a new mode is decoded with the new set.
  assign w_apply = (r_state == ST_PEND) && en && pix_ce && w_frame_wrap;
  assign w_dec   = w_apply ? r_pnd : r_act;

  assign w_hs_start = {2'b00, w_dec[0]} + {2'b00, w_dec[1]};
  assign w_hs_end   = w_hs_start + {2'b00, w_dec[2]};
  assign w_vs_start = {2'b00, w_dec[4]} + {2'b00, w_dec[5]};
  assign w_vs_end   = w_vs_start + {2'b00, w_dec[6]};
  assign w_hs_n     = !(({2'b00, w_nh} >= w_hs_start) && ({2'b00, w_nh} < w_hs_end));
  assign w_vs_n     = !(({2'b00, w_nv} >= w_vs_start) && ({2'b00, w_nv} < w_vs_end));
  assign w_de_n     = (w_nh < w_dec[0]) && (w_nv < w_dec[4]);

  always_comb begin
    w_state_nxt   = r_state;
    w_first_nxt   = r_first;
    w_act_nxt     = r_act;
    w_pnd_nxt     = r_pnd;
    w_applied_nxt = 1'b0;
    w_err_nxt     = w_accept && !w_cfg_ok;
    w_adv         = 1'b0;
    w_idle_out    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_cfg_ok) begin
          w_act_nxt     = w_cfg;
          w_applied_nxt = 1'b1;
        end
        if (en) begin
          w_state_nxt = ST_RUN;
          w_first_nxt = 1'b1;
        end
      end
      ST_RUN, ST_PEND: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
          w_idle_out  = 1'b1;
          if (r_state == ST_PEND) begin
            w_act_nxt     = r_pnd;
            w_applied_nxt = 1'b1;
          end else if (w_accept && w_cfg_ok) begin
            w_act_nxt     = w_cfg;
            w_applied_nxt = 1'b1;
          end
        end else begin
          if (w_accept && w_cfg_ok) begin
            w_pnd_nxt   = w_cfg;
            w_state_nxt = ST_PEND;
          end
          if (pix_ce) begin
            w_adv       = 1'b1;
            w_first_nxt = 1'b0;
            if (w_apply) begin
              w_act_nxt     = r_pnd;
              w_applied_nxt = 1'b1;
              w_state_nxt   = ST_RUN;
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_first   <= 1'b0;
      r_act     <= DEF_SET;
      r_pnd     <= '0;
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_de      <= 1'b0;
      r_ls      <= 1'b0;
      r_fs      <= 1'b0;
      r_applied <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_first   <= w_first_nxt;
      r_act     <= w_act_nxt;
      r_pnd     <= w_pnd_nxt;
      r_applied <= w_applied_nxt;
      r_err     <= w_err_nxt;
      if (w_idle_out) begin
        r_hcnt <= '0;
        r_vcnt <= '0;
        r_hs   <= 1'b1;
        r_vs   <= 1'b1;
        r_de   <= 1'b0;
        r_ls   <= 1'b0;
        r_fs   <= 1'b0;
      end else if (w_adv) begin
        r_hcnt <= w_nh;
        r_vcnt <= w_nv;
        r_hs   <= w_hs_n;
        r_vs   <= w_vs_n;
        r_de   <= w_de_n;
        r_ls   <= (w_nh == 11'd0);
        r_fs   <= (w_nh == 11'd0) && (w_nv == 11'd0);
      end
    end
  end

  assign HCNT        = r_hcnt;
  assign VCNT        = r_vcnt;
  assign HS          = r_hs;
  assign VS          = r_vs;
  assign DE          = r_de;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
  assign cfg_applied = r_applied;
  assign cfg_err     = r_err;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller: small timing sets keep whole frames short.
module tb_vga_timing_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_ce = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready, cfg_err, HS, VS, DE, line_start, frame_start, cfg_applied;
  logic [10:0] cfg_h_visible = '0, cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0;
  logic [10:0] cfg_v_visible = '0, cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0;
  logic [10:0] HCNT, VCNT;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference pixel position and the timing set it is decoded with.
  int mh, mv;
  int m_h[4], m_v[4], p_h[4], p_v[4], c_h[4], c_v[4];
  bit m_first, m_pend, m_app;

  vga_timing_controller dut (
    .clk          (clk),
    .rst          (rst),
    .pix_ce       (pix_ce),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_h_visible(cfg_h_visible),
    .cfg_h_fp     (cfg_h_fp),
    .cfg_h_sync   (cfg_h_sync),
    .cfg_h_bp     (cfg_h_bp),
    .cfg_v_visible(cfg_v_visible),
    .cfg_v_fp     (cfg_v_fp),
    .cfg_v_sync   (cfg_v_sync),
    .cfg_v_bp     (cfg_v_bp),
    .cfg_err      (cfg_err),
    .HCNT         (HCNT),
    .VCNT         (VCNT),
    .HS           (HS),
    .VS           (VS),
    .DE           (DE),
    .line_start   (line_start),
    .frame_start  (frame_start),
    .cfg_applied  (cfg_applied)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int h0, h1, h2, h3, v0, v1, v2, v3);
    cfg_h_visible = 11'(h0); cfg_h_fp = 11'(h1); cfg_h_sync = 11'(h2); cfg_h_bp = 11'(h3);
    cfg_v_visible = 11'(v0); cfg_v_fp = 11'(v1); cfg_v_sync = 11'(v2); cfg_v_bp = 11'(v3);
    c_h = '{h0, h1, h2, h3};
    c_v = '{v0, v1, v2, v3};
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_hcnt"}, 32'(HCNT), 0);
    check_eq({tag, "_vcnt"}, 32'(VCNT), 0);
    check_eq({tag, "_hs"}, 32'(HS), 1);
    check_eq({tag, "_vs"}, 32'(VS), 1);
    check_eq({tag, "_de"}, 32'(DE), 0);
    check_eq({tag, "_ls"}, 32'(line_start), 0);
    check_eq({tag, "_fs"}, 32'(frame_start), 0);
  endtask

  task automatic m_adv();
    m_app = 1'b0;
    if (m_first) begin
      mh = 0; mv = 0; m_first = 1'b0;
    end else if (mh == m_h[0] + m_h[1] + m_h[2] + m_h[3] - 1) begin
      mh = 0;
      if (mv == m_v[0] + m_v[1] + m_v[2] + m_v[3] - 1) begin
        mv = 0;
        if (m_pend) begin
          m_h = p_h; m_v = p_v; m_pend = 1'b0; m_app = 1'b1;
        end
      end else begin
        mv++;
      end
    end else begin
      mh++;
    end
  endtask

  task automatic check_px();
    int hs0, vs0;
    hs0 = m_h[0] + m_h[1];
    vs0 = m_v[0] + m_v[1];
    check_eq("hcnt", 32'(HCNT), mh);
    check_eq("vcnt", 32'(VCNT), mv);
    check_eq("hs", 32'(HS), (mh >= hs0 && mh < hs0 + m_h[2]) ? 0 : 1);
    check_eq("vs", 32'(VS), (mv >= vs0 && mv < vs0 + m_v[2]) ? 0 : 1);
    check_eq("de", 32'(DE), (mh < m_h[0] && mv < m_v[0]) ? 1 : 0);
    check_eq("line_start", 32'(line_start), (mh == 0) ? 1 : 0);
    check_eq("frame_start", 32'(frame_start), (mh == 0 && mv == 0) ? 1 : 0);
    check_eq("cfg_applied", 32'(cfg_applied), 32'(m_app));
  endtask

  task automatic run_px(input int n, input int per);
    for (int i = 0; i < n; i++) begin
      pix_ce = (i % per == 0);
      tick();
      if (pix_ce) begin
        m_adv();
        check_px();
      end else begin
        check_eq("hold_hcnt", 32'(HCNT), mh);
        check_eq("hold_vcnt", 32'(VCNT), mv);
        check_eq("hold_applied", 32'(cfg_applied), 0);
      end
    end
    pix_ce = 1'b0;
  endtask

  task automatic offer_run();
    cfg_valid = 1'b1; pix_ce = 1'b1;
    tick();
    cfg_valid = 1'b0;
    m_adv();
    check_px();
    p_h = c_h; p_v = c_v; m_pend = 1'b1;
    check_eq("ready_pend", 32'(cfg_ready), 0);
  endtask

  task automatic offer_bad_run(input string tag);
    cfg_valid = 1'b1; pix_ce = 1'b1;
    tick();
    cfg_valid = 1'b0;
    m_adv();
    check_px();
    check_eq({tag, "_err"}, 32'(cfg_err), 1);
    check_eq({tag, "_ready"}, 32'(cfg_ready), 1);
    tick();
    m_adv();
    check_px();
    check_eq({tag, "_err_clr"}, 32'(cfg_err), 0);
  endtask

  task automatic offer_idle(input string tag, input bit ok);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check_eq({tag, "_applied"}, 32'(cfg_applied), 32'(ok));
    check_eq({tag, "_err"}, 32'(cfg_err), 32'(!ok));
    check_eq({tag, "_ready"}, 32'(cfg_ready), 1);
    if (ok) begin
      m_h = c_h; m_v = c_v;
    end
    tick();
    check_eq({tag, "_applied_clr"}, 32'(cfg_applied), 0);
    check_eq({tag, "_err_clr"}, 32'(cfg_err), 0);
  endtask

  task automatic start_run(input string tag);
    en = 1'b1; pix_ce = 1'b1;
    tick();
    check_idle(tag);
    m_first = 1'b1; mh = 0; mv = 0;
  endtask

  initial begin
    m_h = '{640, 16, 96, 48};
    m_v = '{480, 10, 2, 33};
    m_pend = 1'b0; m_first = 1'b0; m_app = 1'b0; mh = 0; mv = 0;

    // Reset and default timing, first line plus wrap into line 1.
    tick(); tick();
    check_idle("rst");
    check_eq("rst_ready", 32'(cfg_ready), 1);
    check_eq("rst_err", 32'(cfg_err), 0);
    check_eq("rst_applied", 32'(cfg_applied), 0);
    rst = 1'b1;
    start_run("enter_run");
    run_px(805, 1);

    // Rejected sets leave timing running unchanged.
    set_cfg(640, 16, 0, 48, 480, 10, 2, 33);
    offer_bad_run("zero_sync");
    set_cfg(2000, 25, 25, 50, 480, 10, 2, 33);
    offer_bad_run("ht_2100");
    run_px(20, 1);

    // Back to idle; boundary acceptance in IDLE.
    en = 1'b0;
    tick();
    check_idle("to_idle");
    check_eq("to_idle_applied", 32'(cfg_applied), 0);
    set_cfg(2000, 16, 16, 16, 480, 10, 2, 33);
    offer_idle("ht_2048", 1'b1);
    set_cfg(640, 16, 96, 48, 2000, 16, 16, 17);
    offer_idle("vt_2049", 1'b0);
    set_cfg(4, 2, 3, 1, 3, 1, 2, 1);
    offer_idle("set_a", 1'b1);

    // Set A (10x7) with a 1-in-4 pixel enable.
    start_run("run_a");
    run_px(600, 4);

    // Mid-frame mode change to set B (12x5): old timing until the frame wrap.
    run_px(25, 1);
    set_cfg(6, 2, 2, 2, 2, 1, 1, 1);
    offer_run();
    run_px(80, 1);
    check_eq("ready_after_b", 32'(cfg_ready), 1);

    // Acceptance on the wrap pixel applies at the end of the following frame.
    for (int i = 0; i < 100 && !(mh == 11 && mv == 4); i++) run_px(1, 1);
    check_eq("at_wrap_h", 32'(HCNT), 11);
    check_eq("at_wrap_v", 32'(VCNT), 4);
    set_cfg(4, 2, 3, 1, 3, 1, 2, 1);
    offer_run();
    run_px(130, 1);

    // Drop en while pending: pending set applied at once, raster idles.
    set_cfg(3, 1, 1, 1, 2, 1, 1, 1);
    offer_run();
    run_px(3, 1);
    en = 1'b0; pix_ce = 1'b1;
    tick();
    check_idle("en_drop");
    check_eq("en_drop_applied", 32'(cfg_applied), 1);
    check_eq("en_drop_ready", 32'(cfg_ready), 1);
    m_h = p_h; m_v = p_v; m_pend = 1'b0;
    start_run("restart_c");
    run_px(35, 1);

    // Reset while pending: defaults back, pending lost.
    set_cfg(4, 2, 3, 1, 3, 1, 2, 1);
    offer_run();
    run_px(4, 1);
    rst = 1'b0;
    tick();
    check_idle("rst_pend");
    check_eq("rst_pend_ready", 32'(cfg_ready), 1);
    check_eq("rst_pend_applied", 32'(cfg_applied), 0);
    rst = 1'b1;
    m_h = '{640, 16, 96, 48};
    m_v = '{480, 10, 2, 33};
    m_pend = 1'b0;
    start_run("after_rst");
    run_px(760, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
